// File: rtl/ula_arbiter.sv
// ula_arbiter: shares one registered 6-bit ULA between N_REQ requesters.
// A single operation is in flight at a time: IDLE accepts one request,
// ISSUE drives the ULA operand bus, WAIT counts out the ULA latency and
// RESP holds the captured result until the winning requester takes it.
//
// Handshakes: a transfer happens on a rising edge where valid and ready
// are both high; valid never depends on ready, ready may depend on valid,
// and a response holds valid with stable data until its ready is seen.
//
// Build option: define ULA_ARB_FIXED_PRIO_EN for fixed priority (lowest
// index wins, no pointer register); the default build is round-robin.
module ula_arbiter #(
    parameter int N_REQ       = 4,
    parameter int ALU_LATENCY = 2
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [6*N_REQ-1:0] req_a,
    input  logic [6*N_REQ-1:0] req_b,
    input  logic [3*N_REQ-1:0] req_op,
    input  logic [N_REQ-1:0]   req_modo,
    output logic [5:0]         alu_a,
    output logic [5:0]         alu_b,
    output logic [2:0]         alu_op,
    output logic               alu_modo,
    input  logic [6:0]         alu_result,
    input  logic               alu_overflow,
    output logic [N_REQ-1:0]   rsp_valid,
    input  logic [N_REQ-1:0]   rsp_ready,
    output logic [6:0]         rsp_result,
    output logic               rsp_overflow,
    output logic               rsp_zero,
    output logic               busy,
    output logic [1:0]         dbg_state
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int CW = (ALU_LATENCY > 1) ? $clog2(ALU_LATENCY) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(ALU_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] gnt_q;
    logic [5:0]    opa_q, opb_q;
    logic [2:0]    opop_q;
    logic          opmodo_q;
    logic [5:0]    alu_a_q, alu_b_q;
    logic [2:0]    alu_op_q;
    logic          alu_modo_q;
    logic [6:0]    res_q;
    logic          ovf_q;
    logic          zero_q;
`ifndef ULA_ARB_FIXED_PRIO_EN
    logic [IW-1:0] ptr_q;
`endif

    logic [IW-1:0] win_idx;
    logic [IW-1:0] cand;
    logic          win_found;
    logic          accept;

    // Arbitration: first valid requester found from the search start.
    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        for (int k = 0; k < N_REQ; k++) begin
`ifdef ULA_ARB_FIXED_PRIO_EN
            cand = IW'(k);
`else
            cand = IW'((int'(ptr_q) + k) % N_REQ);
`endif
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
            end
        end
    end

    // Grant is offered only in IDLE and never while reset is asserted.
    always_comb begin
        req_ready = '0;
        if (state_q == IDLE && !reset && win_found) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    assign accept = |(req_valid & req_ready);

    // Next-state and latency counter for the one-operation-in-flight FSM.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (accept) state_d = ISSUE;
            end
            ISSUE: begin
                state_d = WAIT;
                cnt_d   = CNT_LOAD;
            end
            WAIT: begin
                if (cnt_q == '0) state_d = RESP;
                else             cnt_d   = cnt_q - CW'(1);
            end
            RESP: begin
                if (rsp_ready[gnt_q]) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // FSM state and counter registers.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Datapath: latch on acceptance, drive ULA on issue, capture at count 0.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            gnt_q      <= '0;
            opa_q      <= '0;
            opb_q      <= '0;
            opop_q     <= '0;
            opmodo_q   <= 1'b0;
            alu_a_q    <= '0;
            alu_b_q    <= '0;
            alu_op_q   <= '0;
            alu_modo_q <= 1'b0;
            res_q      <= '0;
            ovf_q      <= 1'b0;
            zero_q     <= 1'b0;
`ifndef ULA_ARB_FIXED_PRIO_EN
            ptr_q      <= '0;
`endif
        end else begin
            if (accept) begin
                gnt_q    <= win_idx;
                opa_q    <= req_a[6*win_idx +: 6];
                opb_q    <= req_b[6*win_idx +: 6];
                opop_q   <= req_op[3*win_idx +: 3];
                opmodo_q <= req_modo[win_idx];
`ifndef ULA_ARB_FIXED_PRIO_EN
                ptr_q    <= (win_idx == IW'(N_REQ - 1)) ? '0 : win_idx + IW'(1);
`endif
            end
            if (state_q == ISSUE) begin
                alu_a_q    <= opa_q;
                alu_b_q    <= opb_q;
                alu_op_q   <= opop_q;
                alu_modo_q <= opmodo_q;
            end
            if (state_q == WAIT && cnt_q == '0) begin
                res_q  <= alu_result;
                ovf_q  <= alu_overflow;
                // Bit 6 is carry/borrow and does not count towards zero.
                zero_q <= (alu_result[5:0] == 6'd0);
            end
        end
    end

    // Response is one-hot on the latched grant while in RESP.
    always_comb begin
        rsp_valid = '0;
        if (state_q == RESP) begin
            rsp_valid[gnt_q] = 1'b1;
        end
    end

    assign alu_a        = alu_a_q;
    assign alu_b        = alu_b_q;
    assign alu_op       = alu_op_q;
    assign alu_modo     = alu_modo_q;
    assign rsp_result   = res_q;
    assign rsp_overflow = ovf_q;
    assign rsp_zero     = zero_q;
    assign busy         = (state_q != IDLE);
    assign dbg_state    = state_q;

endmodule

// File: doc/ula_arbiter.md
# ula_arbiter

Shares a single registered 6-bit ULA between `N_REQ` requesters. Each requester presents one operation (A, B, operacao, modo) with a valid/ready handshake. The arbiter grants one request at a time, drives the shared ULA operand bus and waits a fixed pipeline latency. It then returns the 7-bit result, overflow and a locally computed zero flag to the winning requester. It sits between the requester blocks and the ULA instance, and is the only driver of the ULA operand inputs.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8).
- `ALU_LATENCY`, 2, clock edges from operands first present on `alu_*` to a valid `alu_result`. Range ≥1. The registered ULA needs 2.

Ports:
- `CLOCK_50`, in, 1, single clock; everything is on its rising edge.
- `reset`, in, 1, synchronous, active-high.
- `req_valid`, in, N_REQ, request pending, one bit per requester.
- `req_ready`, out, N_REQ, one-hot grant/accept.
- `req_a`, in, 6*N_REQ, operand A. Requester i uses bits [6i+5:6i].
- `req_b`, in, 6*N_REQ, operand B, packed the same way.
- `req_op`, in, 3*N_REQ, operacao. Requester i uses bits [3i+2:3i].
- `req_modo`, in, N_REQ, 1 = logic operation, 0 = arithmetic operation.
- `alu_a`, out, 6, operand A to the ULA.
- `alu_b`, out, 6, operand B to the ULA.
- `alu_op`, out, 3, operation code to the ULA.
- `alu_modo`, out, 1, mode to the ULA.
- `alu_result`, in, 7, ULA result.
- `alu_overflow`, in, 1, ULA overflow.
- `rsp_valid`, out, N_REQ, one-hot; marks which requester the response belongs to.
- `rsp_ready`, in, N_REQ, response accepted, one bit per requester.
- `rsp_result`, out, 7, captured result.
- `rsp_overflow`, out, 1, captured overflow.
- `rsp_zero`, out, 1, set when `rsp_result[5:0]==0`.
- `busy`, out, 1, high in every state other than IDLE.

## Operation
- The FSM has four states: IDLE, ISSUE, WAIT, RESP.
- **IDLE**
  - `req_ready` is combinational and one-hot on the arbitration winner, only while some `req_valid` is set.
  - Acceptance is `req_valid[g] & req_ready[g]`.
  - On acceptance: latch operands and the grant index, then go to ISSUE.
- **ISSUE** (1 cycle)
  - `alu_*` take the latched operands.
  - Latency counter loads `ALU_LATENCY-1`.
  - Go to WAIT.
- **WAIT**
  - Counter decrements each cycle.
  - At 0: capture `alu_result` and `alu_overflow`, compute `rsp_zero`, go to RESP.
- **RESP**
  - `rsp_valid[g]` holds with stable data until `rsp_ready[g]`.
  - On that handshake, go to IDLE. Other `rsp_ready` bits are ignored.
- **Arbitration**
  - Round-robin. The pointer advances to grant index + 1 (mod `N_REQ`) on acceptance only.
  - Search starts at the pointer.
- `alu_*` hold the last issued operands after completion. They do not return to 0.
- A request raised or dropped while busy is not sampled. Only one operation is ever in flight.
- `req_*` operand fields are only sampled in the acceptance cycle.

## Timing
- Reset values:
  - `req_ready`=0, `rsp_valid`=0.
  - `rsp_result`=0, `rsp_overflow`=0, `rsp_zero`=0.
  - `alu_a`/`alu_b`/`alu_op`/`alu_modo`=0.
  - `busy`=0, pointer=0, state IDLE.
- Latency: acceptance at edge T, `alu_*` valid after edge T+1, result captured at edge T+1+`ALU_LATENCY`. `rsp_valid` is high from that edge.
- Throughput: a new acceptance is possible in the cycle after the response handshake.
- Minimum period is `ALU_LATENCY`+3 cycles per operation when `rsp_ready` is held high.
- Reset during ISSUE, WAIT or RESP abandons the operation: no response, pointer back to 0.
- Reset has priority over every handshake in the same cycle.
- All requesters valid simultaneously: exactly one `req_ready` bit is set, chosen by the pointer.
- Pointer wrap-around: a grant to requester `N_REQ-1` moves the pointer to 0.
- `rsp_zero` ignores bit 6 of the result.

## Configuration
- `ULA_ARB_FIXED_PRIO_EN` defined: fixed priority, lowest index wins. The pointer register is removed.
- `ULA_ARB_FIXED_PRIO_EN` undefined (default): round-robin as described above.

## Test plan
- **Single request:** reset; req0 A=5, B=3, modo=0, op=000 with a model ULA of latency 2 returning 8. Required: `req_ready`=0001 at edge T, `rsp_valid`=0001 at T+3, result=8, zero=0, overflow=0.
- **Round-robin, all four valid:** four requests continuously asserted, `rsp_ready` held high. Required grant order 0,1,2,3,0. Each grant is separated by 5 cycles.
- **Zero flag and wrap:** req2 modo=1, op=100, A=B=6'h2A. Model returns 0. Required: `rsp_zero`=1 and `rsp_valid`=0100.
- **Response backpressure:** hold `rsp_ready`=0 for 10 cycles. Required:
  - `rsp_valid` and `rsp_result` stay stable.
  - `busy`=1.
  - A pending req1 receives no `req_ready`.
- **Reset mid-WAIT:** assert `reset` one cycle after ISSUE. Required:
  - No `rsp_valid` ever appears for that operation.
  - Outputs read reset values next cycle.
  - The next grant goes to the lowest valid index.
- **Fixed-priority build** (`ULA_ARB_FIXED_PRIO_EN`): req1 and req3 both valid continuously. Required: req1 is granted every time and req3 is never granted.
